// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch stage and the decode controller:
// data width, major opcodes and the branch-type encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    BR_EQ   = 3'b000,
    BR_NE   = 3'b001,
    BR_LT   = 3'b010,
    BR_GE   = 3'b011,
    BR_LTU  = 3'b100,
    BR_GEU  = 3'b101,
    BR_JUMP = 3'b110,
    BR_NONE = 3'b111
  } br_type_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} entries. Flush wins over
// push/pop; a pop in the same cycle frees space for a push when full.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= wdata;
  end

  // Upstream throttling keeps in-flight plus buffered words within DEPTH.
  always_ff @(posedge clk) begin
    if (!rst && !flush) assert (!(push && full && !pop));
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, in-order imem requests capped by buffer space,
// {pc, instr} FIFO toward decode, and branch resolve/redirect with squash.
module fetch_unit import riscv_pkg::*; #(
  parameter int              XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  input  logic            br_valid,
  input  logic [2:0]      br_type,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] br_target,
  output logic            br_taken,
  output logic            misalign
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc, rsp_pc, redirect_pc;
  logic [CW-1:0]   outstanding, outstanding_nxt, drop, fifo_count;
  logic [CW:0]     occupancy;
  logic            req_fire, br_cond;
  logic            fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [XLEN+31:0] fifo_rdata;

  assign occupancy       = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid  = !rst && (occupancy < (CW+1)'(BUF_DEPTH));
  assign imem_req_addr   = fetch_pc;
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
  assign redirect_pc     = {br_target[XLEN-1:2], 2'b00};

  always_comb begin
    br_cond = 1'b0;
    case (br_type)
      BR_EQ:   br_cond = (rs1_data == rs2_data);
      BR_NE:   br_cond = (rs1_data != rs2_data);
      BR_LT:   br_cond = ($signed(rs1_data) <  $signed(rs2_data));
      BR_GE:   br_cond = ($signed(rs1_data) >= $signed(rs2_data));
      BR_LTU:  br_cond = (rs1_data <  rs2_data);
      BR_GEU:  br_cond = (rs1_data >= rs2_data);
      BR_JUMP: br_cond = 1'b1;
      default: br_cond = 1'b0;
    endcase
  end

  assign br_taken = br_valid && br_cond;

  // A redirect flushes the FIFO, so same-cycle push/pop are squashed too.
  assign fifo_push = imem_rsp_valid && (drop == '0) && !br_taken;
  assign fifo_pop  = instr_valid && instr_ready && !br_taken;

  fetch_fifo #(.DEPTH(BUF_DEPTH), .W(XLEN + 32)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (br_taken),
    .wdata ({rsp_pc, imem_rsp_data}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign instr_valid = !rst && !fifo_empty;
  assign instr       = fifo_rdata[31:0];
  assign instr_pc    = fifo_rdata[XLEN+31:32];
  assign opcode      = instr[6:0];
  assign func3       = instr[14:12];
  assign func7       = instr[31:25];

  // rsp_pc is the PC of the next response that will be kept, so it only
  // advances on kept words and jumps to the target on redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      misalign    <= 1'b0;
    end else begin
      outstanding <= outstanding_nxt;
      misalign    <= br_taken && (br_target[1:0] != 2'b00);
      if (br_taken) begin
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        drop     <= outstanding_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (imem_rsp_valid) begin
          if (drop != '0) drop   <= drop - 1'b1;
          else            rsp_pc <= rsp_pc + XLEN'(4);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rsp_valid && outstanding == '0));
      assert (!(fifo_push && fifo_full && !fifo_pop));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order imem model (1-cycle latency,
// response hold control) and a decode-side collector of delivered instructions.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic [6:0]  opcode, func7;
  logic [2:0]  func3;
  logic        br_valid;
  logic [2:0]  br_type;
  logic [31:0] rs1_data, rs2_data, br_target;
  logic        br_taken, misalign;
  logic        hold;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } dlv_t;

  dlv_t        dq[$];
  logic [31:0] mq[$];
  int          fires = 0;
  int          checks = 0, errors = 0;

  always #10 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .func3(func3), .func7(func7),
    .br_valid(br_valid), .br_type(br_type), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .br_target(br_target), .br_taken(br_taken), .misalign(misalign)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h0050_0093 + (a << 20);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      imem_rsp_valid <= 1'b0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back(imem_req_addr);
        fires <= fires + 1;
      end
      if (!hold && mq.size() > 0) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= word(mq.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && instr_valid && instr_ready && !br_taken)
      dq.push_back('{instr_pc, instr, opcode, func3, func7});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_dlv(input int n);
    for (int i = 0; i < 60 && dq.size() < n; i++) @(negedge clk);
    if (dq.size() < n) chk("dlv_timeout", 32'(dq.size()), 32'(n));
  endtask

  task automatic try_br(input string tag, input logic v, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] b, input logic exp);
    br_valid = v; br_type = t; rs1_data = a; rs2_data = b;
    #1 chk(tag, 32'(br_taken), 32'(exp));
  endtask

  initial begin
    int n0, f0, bidx, jidx, cidx;
    bit found;
    rst = 1'b1; imem_req_ready = 1'b0; instr_ready = 1'b0; hold = 1'b0;
    br_valid = 1'b0; br_type = 3'b111; rs1_data = '0; rs2_data = '0; br_target = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_instr_valid", 32'(instr_valid), 0);
    chk("rst_misalign", 32'(misalign), 0);
    chk("rst_addr", imem_req_addr, 32'h0);

    rst = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
    #1 chk("req_after_rst", 32'(imem_req_valid), 1);
    wait_dlv(1);
    chk("first_pc", dq[0].pc, 32'h0);
    chk("first_instr", dq[0].ins, 32'h0050_0093);
    chk("first_opcode", 32'(dq[0].op), 32'h13);
    chk("first_func3", 32'(dq[0].f3), 0);
    chk("first_func7", 32'(dq[0].f7), 0);
    repeat (8) @(negedge clk);

    // decode stall: requests stop once buffer space is exhausted
    instr_ready = 1'b0; n0 = dq.size(); f0 = fires;
    repeat (10) @(negedge clk);
    chk("stall_fires_le_depth", 32'((fires - f0) <= 2), 1);
    chk("stall_req_valid", 32'(imem_req_valid), 0);
    chk("stall_instr_valid", 32'(instr_valid), 1);
    chk("stall_no_pop", 32'(dq.size()), 32'(n0));
    instr_ready = 1'b1;
    wait_dlv(n0 + 4);
    for (int k = 0; k < n0 + 4; k++) begin
      chk("seq_pc", dq[k].pc, 32'(4 * k));
      chk("seq_instr", dq[k].ins, word(32'(4 * k)));
    end

    // BEQ taken with two requests in flight
    hold = 1'b1;
    repeat (6) @(negedge clk);
    chk("hold_req_valid", 32'(imem_req_valid), 0);
    chk("hold_inflight", 32'(mq.size()), 2);
    chk("hold_drained", 32'(instr_valid), 0);
    br_valid = 1'b1; br_type = 3'b000; rs1_data = 5; rs2_data = 5; br_target = 32'h100;
    bidx = dq.size();
    #1 chk("beq_taken", 32'(br_taken), 1);
    @(negedge clk);
    br_valid = 1'b0; hold = 1'b0;
    chk("beq_flush", 32'(instr_valid), 0);
    chk("beq_addr", imem_req_addr, 32'h100);
    chk("beq_misalign", 32'(misalign), 0);
    wait_dlv(bidx + 2);
    chk("beq_pc0", dq[bidx].pc, 32'h100);
    chk("beq_instr0", dq[bidx].ins, word(32'h100));
    chk("beq_pc1", dq[bidx + 1].pc, 32'h104);

    // comparator table, all settled before the next edge
    @(negedge clk);
    try_br("blt_neg", 1, 3'b010, 32'hFFFF_FFFF, 32'h1, 1);
    try_br("beq_ne", 1, 3'b000, 5, 6, 0);
    try_br("bne", 1, 3'b001, 5, 6, 1);
    try_br("bge_pos", 1, 3'b011, 32'h1, 32'hFFFF_FFFF, 1);
    try_br("bgeu", 1, 3'b101, 32'h1, 32'hFFFF_FFFF, 0);
    try_br("bge_eq", 1, 3'b011, 7, 7, 1);
    try_br("none", 1, 3'b111, 0, 0, 0);
    try_br("jump_novalid", 0, 3'b110, 0, 0, 0);
    try_br("bltu_neg", 1, 3'b100, 32'hFFFF_FFFF, 32'h1, 0);
    @(negedge clk);
    br_valid = 1'b0; br_type = 3'b111;
    wait_dlv(bidx + 6);
    for (int j = 0; j < 6; j++) chk("no_redirect_pc", dq[bidx + j].pc, 32'(32'h100 + 4 * j));

    // misaligned jump
    br_valid = 1'b1; br_type = 3'b110; br_target = 32'h202;
    jidx = dq.size();
    #1 chk("jump_taken", 32'(br_taken), 1);
    @(negedge clk);
    br_valid = 1'b0; br_type = 3'b111;
    chk("misalign_pulse", 32'(misalign), 1);
    chk("jump_addr", imem_req_addr, 32'h200);
    @(negedge clk);
    chk("misalign_clear", 32'(misalign), 0);
    wait_dlv(jidx + 1);
    chk("jump_pc", dq[jidx].pc, 32'h200);

    // redirect coinciding with a response and a request handshake
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_rsp_valid && imem_req_valid && imem_req_ready) found = 1;
      else @(negedge clk);
    end
    chk("coincide_found", 32'(found), 1);
    br_valid = 1'b1; br_type = 3'b110; br_target = 32'h300;
    cidx = dq.size();
    #1 chk("coincide_taken", 32'(br_taken), 1);
    @(negedge clk);
    br_valid = 1'b0; br_type = 3'b111;
    chk("coincide_flush", 32'(instr_valid), 0);
    chk("coincide_drop", 32'(dut.drop), 1);
    wait_dlv(cidx + 2);
    chk("coincide_pc0", dq[cidx].pc, 32'h300);
    chk("coincide_instr0", dq[cidx].ins, word(32'h300));
    chk("coincide_pc1", dq[cidx + 1].pc, 32'h304);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
